reg_file: RTL

//  Architectural register file of the single-cycle datapath: 2 combinational read ports
//  (rs, rt) and 1 synchronous write port. Write address arrives from the 5-bit destination
//  mux (rt/rd select); write data comes from the writeback mux.

---
 rtl/reg_file.sv | 89 ++++++++
 1 files changed

// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file, 2 combinational read ports, 1 write port, debug read
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;

    // Register 0 has no storage; it is synthesised as a constant on every read path.
    logic [DATA_W-1:0] regs [1:DEPTH-1];

    // A write is only meaningful for a non-zero destination outside reset.
    logic wr_en;
    logic wr_live;

    logic [DATA_W-1:0] rs_stored;
    logic [DATA_W-1:0] rt_stored;
    logic [DATA_W-1:0] dbg_stored;

    logic rs_hit;
    logic rt_hit;

    // Decode the write qualifier once so storage and bypass agree on what counts as a write.
    always_comb begin
        wr_en   = reg_write && (wr_addr != '0);
        wr_live = wr_en && !rst;
    end

    // Storage update: reset clears every register and overrides any write in the same cycle.
    always_ff @(posedge clk) begin
        for (int i = 1; i < DEPTH; i++) begin
            if (rst) begin
                regs[i] <= '0;
            end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                regs[i] <= wr_data;
            end
        end
    end

    // Stored-value read muxes; address 0 falls through to the zero default.
    always_comb begin
        rs_stored  = '0;
        rt_stored  = '0;
        dbg_stored = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (rs_addr == ADDR_W'(i)) begin
                rs_stored = regs[i];
            end
            if (rt_addr == ADDR_W'(i)) begin
                rt_stored = regs[i];
            end
            if (dbg_addr == ADDR_W'(i)) begin
                dbg_stored = regs[i];
            end
        end
    end

    // Bypass match per read port; a zero address can never match because wr_live excludes it.
    always_comb begin
        rs_hit = (BYPASS != 0) && wr_live && (rs_addr == wr_addr);
        rt_hit = (BYPASS != 0) && wr_live && (rt_addr == wr_addr);
    end

    // Output selection: reset forces zero, otherwise bypassed or stored data; debug is never bypassed.
    always_comb begin
        rs_data  = '0;
        rt_data  = '0;
        dbg_data = '0;
        if (!rst) begin
            rs_data  = rs_hit ? wr_data : rs_stored;
            rt_data  = rt_hit ? wr_data : rt_stored;
            dbg_data = dbg_stored;
        end
    end

endmodule
